// File: rtl/tthbif_uart_if.sv
// tthbif_uart_if: valid/ready word channels between the tthbif command logic and the UART
interface tthbif_uart_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              rx_ready_i;
    logic              rx_frame_err_o;
    logic              rx_parity_err_o;
    logic              rx_overrun_o;
    modport master (
        output tx_data_i, tx_valid_i, rx_ready_i,
        input  tx_ready_o, rx_data_o, rx_valid_o, rx_frame_err_o, rx_parity_err_o, rx_overrun_o
    );
    modport slave (
        input  tx_data_i, tx_valid_i, rx_ready_i,
        output tx_ready_o, rx_data_o, rx_valid_o, rx_frame_err_o, rx_parity_err_o, rx_overrun_o
    );
endinterface

// File: rtl/tthbif_uart.sv
// tthbif_uart: parametrised full-duplex UART with valid/ready handshakes and per-word error flags
module tthbif_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    tthbif_uart_if.slave bus,
    input  logic         uart_rx_i,
    output logic         uart_tx_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] D_LAST = IW'(DATA_W - 1);
    localparam logic [IW-1:0] S_LAST = IW'(STOP_BITS - 1);
    localparam bit PAR_EN  = PARITY != 0;
    localparam bit PAR_ODD = PARITY == 1;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t            r_tx_state, w_tx_state;
    logic [CW-1:0]     r_tx_cnt, w_tx_cnt;
    logic [IW-1:0]     r_tx_idx, w_tx_idx;
    logic [DATA_W-1:0] r_tx_sh;
    logic              r_tx_par, r_alive, w_tx_tick, w_tx_fire, w_tx_line;

    assign w_tx_tick      = r_tx_cnt == C_LAST;
    assign bus.tx_ready_o = r_alive & en_i & (r_tx_state == ST_IDLE);
    assign w_tx_fire      = bus.tx_ready_o & bus.tx_valid_i;
    assign uart_tx_o      = w_tx_line | ~en_i;

    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_cnt   = w_tx_tick ? '0 : r_tx_cnt + 1'b1;
        w_tx_idx   = r_tx_idx;
        w_tx_line  = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt   = '0;
                w_tx_state = w_tx_fire ? ST_START : ST_IDLE;
            end
            ST_START: begin
                w_tx_line  = 1'b0;
                w_tx_state = w_tx_tick ? ST_DATA : ST_START;
            end
            ST_DATA: begin
                w_tx_line = r_tx_sh[0];
                if (w_tx_tick) begin
                    w_tx_idx   = (r_tx_idx == D_LAST) ? '0 : r_tx_idx + 1'b1;
                    w_tx_state = (r_tx_idx != D_LAST) ? ST_DATA : PAR_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_tx_line  = r_tx_par;
                w_tx_state = w_tx_tick ? ST_STOP : ST_PARITY;
            end
            default: begin
                if (w_tx_tick) begin
                    w_tx_idx   = (r_tx_idx == S_LAST) ? '0 : r_tx_idx + 1'b1;
                    w_tx_state = (r_tx_idx == S_LAST) ? ST_IDLE : ST_STOP;
                end
            end
        endcase
        if (!en_i) begin
            w_tx_state = ST_IDLE;
            w_tx_cnt   = '0;
            w_tx_idx   = '0;
        end
    end

    // r_alive keeps tx_ready_o low until the first edge after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_sh    <= '0;
            r_tx_par   <= 1'b0;
            r_alive    <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_cnt   <= w_tx_cnt;
            r_tx_idx   <= w_tx_idx;
            r_alive    <= 1'b1;
            if (w_tx_fire) begin
                r_tx_sh  <= bus.tx_data_i;
                r_tx_par <= PAR_ODD ? ~^bus.tx_data_i : ^bus.tx_data_i;
            end else if (r_tx_state == ST_DATA && w_tx_tick) begin
                r_tx_sh <= r_tx_sh >> 1;
            end
        end
    end

    logic [1:0]        r_sync;
    state_t            r_rx_state, w_rx_state;
    logic [CW-1:0]     r_rx_cnt, w_rx_cnt;
    logic [IW-1:0]     r_rx_idx, w_rx_idx;
    logic [DATA_W-1:0] r_rx_sh, r_rx_data;
    logic              r_rx_pbit, r_rx_valid, r_rx_ferr, r_rx_perr, r_rx_ovr;
    logic              w_rx_in, w_rx_tick, w_stop_smp, w_rx_hs, w_par_err;

    assign w_rx_in     = r_sync[1];
    assign w_rx_tick   = r_rx_cnt == C_LAST;
    assign w_rx_hs     = r_rx_valid & bus.rx_ready_i;
    assign w_stop_smp  = en_i & (r_rx_state == ST_STOP) & w_rx_tick;
    assign w_par_err   = PAR_EN & (PAR_ODD ? ~^{r_rx_sh, r_rx_pbit} : ^{r_rx_sh, r_rx_pbit});
    assign bus.rx_data_o       = r_rx_data;
    assign bus.rx_valid_o      = r_rx_valid;
    assign bus.rx_frame_err_o  = r_rx_ferr;
    assign bus.rx_parity_err_o = r_rx_perr;
    assign bus.rx_overrun_o    = r_rx_ovr;

    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_cnt   = w_rx_tick ? '0 : r_rx_cnt + 1'b1;
        w_rx_idx   = r_rx_idx;
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_cnt   = '0;
                w_rx_state = w_rx_in ? ST_IDLE : ST_START;
            end
            ST_START: begin
                if (r_rx_cnt == C_HALF) begin
                    w_rx_cnt   = '0;
                    w_rx_state = w_rx_in ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_rx_tick) begin
                    w_rx_idx   = (r_rx_idx == D_LAST) ? '0 : r_rx_idx + 1'b1;
                    w_rx_state = (r_rx_idx != D_LAST) ? ST_DATA : PAR_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: w_rx_state = w_rx_tick ? ST_STOP : ST_PARITY;
            default:   w_rx_state = w_rx_tick ? ST_IDLE : ST_STOP;
        endcase
        if (!en_i) begin
            w_rx_state = ST_IDLE;
            w_rx_cnt   = '0;
            w_rx_idx   = '0;
        end
    end

    // a stop sample that coincides with a handshake reloads instead of overrunning
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync     <= 2'b11;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_sh    <= '0;
            r_rx_pbit  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], uart_rx_i};
            r_rx_state <= w_rx_state;
            r_rx_cnt   <= w_rx_cnt;
            r_rx_idx   <= w_rx_idx;
            if (en_i && r_rx_state == ST_DATA && w_rx_tick) r_rx_sh <= {w_rx_in, r_rx_sh[DATA_W-1:1]};
            if (en_i && r_rx_state == ST_PARITY && w_rx_tick) r_rx_pbit <= w_rx_in;
            if (w_stop_smp && (!r_rx_valid || w_rx_hs)) begin
                r_rx_data  <= r_rx_sh;
                r_rx_ferr  <= ~w_rx_in;
                r_rx_perr  <= w_par_err;
                r_rx_valid <= 1'b1;
            end else if (w_rx_hs) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_hs) r_rx_ovr <= 1'b0;
            else if (w_stop_smp && r_rx_valid) r_rx_ovr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tthbif_uart.sv
// tb_tthbif_uart: directed bench; dut_a is 8N1 for TX, dut_b is 7E2 for RX, both 8 clocks per bit
module tb_tthbif_uart;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic tx_a, tx_b;
    logic v78, v79;
    int checks = 0;
    int errors = 0;

    tthbif_uart_if #(.DATA_W(8)) bus_a ();
    tthbif_uart_if #(.DATA_W(7)) bus_b ();

    tthbif_uart #(.CLKS_PER_BIT(8), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .bus(bus_a), .uart_rx_i(rx_a), .uart_tx_o(tx_a)
    );
    tthbif_uart #(.CLKS_PER_BIT(8), .DATA_W(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .bus(bus_b), .uart_rx_i(rx_b), .uart_tx_o(tx_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // frame bit i is driven during cycles 8i..8i+7 of the frame
    function automatic logic [10:0] mk_b(input logic [6:0] d, input logic pflip, input logic stop1);
        return {1'b1, stop1, (^d) ^ pflip, d, 1'b0};
    endfunction

    task automatic drive_b(input logic [10:0] f, input int lo, input int hi, input int hs);
        for (int off = lo * 8; off < (hi + 1) * 8; off++) begin
            rx_b = f[off/8];
            if (hs >= 0) bus_b.rx_ready_i = (off == hs);
            if (off == 78) v78 = bus_b.rx_valid_o;
            if (off == 79) v79 = bus_b.rx_valid_o;
            tick();
        end
        if (hs >= 0) bus_b.rx_ready_i = 1'b0;
    endtask

    task automatic consume_b();
        bus_b.rx_ready_i = 1'b1;
        tick();
        bus_b.rx_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", tx_a); end
        checks++; if (bus_a.tx_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus_a.tx_ready_o); end
        checks++; if ({bus_b.rx_valid_o, bus_b.rx_data_o, bus_b.rx_frame_err_o, bus_b.rx_parity_err_o, bus_b.rx_overrun_o} !== 11'd0) begin
            errors++; $display("FAIL rst_rx_outputs: got valid=%b data=%h fe=%b pe=%b ov=%b expected all 0", bus_b.rx_valid_o, bus_b.rx_data_o, bus_b.rx_frame_err_o, bus_b.rx_parity_err_o, bus_b.rx_overrun_o);
        end
        rst_n = 1'b1;
        checks++; if (bus_a.tx_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_release: got %b expected 0", bus_a.tx_ready_o); end
        tick();
        checks++; if (bus_a.tx_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", bus_a.tx_ready_o); end
    endtask

    task automatic test_tx_8n1();
        logic [9:0] fr = {1'b1, 8'hA5, 1'b0};
        int n = 0;
        while (bus_a.tx_ready_o !== 1'b1 && n < 200) begin tick(); n++; end
        checks++; if (bus_a.tx_ready_o !== 1'b1) begin errors++; $display("FAIL tx_wait_ready: got %b expected 1", bus_a.tx_ready_o); end
        bus_a.tx_data_i = 8'hA5;
        bus_a.tx_valid_i = 1'b1;
        tick();
        bus_a.tx_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 8; j++) begin
                checks++; if (tx_a !== fr[i]) begin errors++; $display("FAIL tx_a5_bit%0d_cyc%0d: got %b expected %b", i, j, tx_a, fr[i]); end
                checks++; if (bus_a.tx_ready_o !== 1'b0) begin errors++; $display("FAIL tx_busy_bit%0d_cyc%0d: got %b expected 0", i, j, bus_a.tx_ready_o); end
                tick();
            end
        end
        checks++; if (bus_a.tx_ready_o !== 1'b1) begin errors++; $display("FAIL tx_ready_at_81: got %b expected 1", bus_a.tx_ready_o); end
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL tx_idle_at_81: got %b expected 1", tx_a); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] fr = {1'b1, 8'h3C, 1'b0};
        bus_a.tx_data_i = 8'h3C;
        bus_a.tx_valid_i = 1'b1;
        tick();
        bus_a.tx_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (j == 4) begin
                    checks++; if (tx_a !== fr[i]) begin errors++; $display("FAIL b2b_3c_bit%0d: got %b expected %b", i, tx_a, fr[i]); end
                end
                tick();
            end
        end
        checks++; if (bus_a.tx_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", bus_a.tx_ready_o); end
    endtask

    task automatic test_rx_clean();
        drive_b(mk_b(7'h5A, 1'b0, 1'b1), 0, 10, -1);
        checks++; if (v78 !== 1'b0) begin errors++; $display("FAIL rx_valid_at_stop: got %b expected 0", v78); end
        checks++; if (v79 !== 1'b1) begin errors++; $display("FAIL rx_valid_after_stop: got %b expected 1", v79); end
        checks++; if (bus_b.rx_data_o !== 7'h5A) begin errors++; $display("FAIL rx_clean_data: got %h expected 5a", bus_b.rx_data_o); end
        checks++; if ({bus_b.rx_frame_err_o, bus_b.rx_parity_err_o} !== 2'b00) begin errors++; $display("FAIL rx_clean_flags: got fe=%b pe=%b expected 0 0", bus_b.rx_frame_err_o, bus_b.rx_parity_err_o); end
        consume_b();
        checks++; if (bus_b.rx_valid_o !== 1'b0) begin errors++; $display("FAIL rx_clean_consume: got %b expected 0", bus_b.rx_valid_o); end
    endtask

    task automatic test_rx_parity();
        drive_b(mk_b(7'h5A, 1'b1, 1'b1), 0, 10, -1);
        checks++; if (bus_b.rx_valid_o !== 1'b1) begin errors++; $display("FAIL rx_par_valid: got %b expected 1", bus_b.rx_valid_o); end
        checks++; if (bus_b.rx_data_o !== 7'h5A) begin errors++; $display("FAIL rx_par_data: got %h expected 5a", bus_b.rx_data_o); end
        checks++; if ({bus_b.rx_frame_err_o, bus_b.rx_parity_err_o} !== 2'b01) begin errors++; $display("FAIL rx_par_flags: got fe=%b pe=%b expected 0 1", bus_b.rx_frame_err_o, bus_b.rx_parity_err_o); end
        consume_b();
    endtask

    task automatic test_rx_frame_err();
        drive_b(mk_b(7'h33, 1'b0, 1'b0), 0, 10, -1);
        checks++; if (bus_b.rx_data_o !== 7'h33) begin errors++; $display("FAIL rx_ferr_data: got %h expected 33", bus_b.rx_data_o); end
        checks++; if ({bus_b.rx_valid_o, bus_b.rx_frame_err_o, bus_b.rx_parity_err_o} !== 3'b110) begin
            errors++; $display("FAIL rx_ferr_flags: got v=%b fe=%b pe=%b expected 1 1 0", bus_b.rx_valid_o, bus_b.rx_frame_err_o, bus_b.rx_parity_err_o);
        end
        consume_b();
    endtask

    task automatic test_false_start();
        logic seen = 1'b0;
        rx_b = 1'b0;
        repeat (2) tick();
        rx_b = 1'b1;
        repeat (40) begin
            if (bus_b.rx_valid_o !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL false_start: got valid seen=%b expected 0", seen); end
    endtask

    task automatic test_overrun();
        bus_b.rx_ready_i = 1'b0;
        drive_b(mk_b(7'h11, 1'b0, 1'b1), 0, 10, -1);
        tick();
        drive_b(mk_b(7'h22, 1'b0, 1'b1), 0, 10, -1);
        checks++; if (bus_b.rx_data_o !== 7'h11) begin errors++; $display("FAIL ovr_data: got %h expected 11", bus_b.rx_data_o); end
        checks++; if ({bus_b.rx_valid_o, bus_b.rx_overrun_o} !== 2'b11) begin errors++; $display("FAIL ovr_flags: got v=%b ov=%b expected 1 1", bus_b.rx_valid_o, bus_b.rx_overrun_o); end
        consume_b();
        checks++; if ({bus_b.rx_valid_o, bus_b.rx_overrun_o} !== 2'b00) begin errors++; $display("FAIL ovr_clear: got v=%b ov=%b expected 0 0", bus_b.rx_valid_o, bus_b.rx_overrun_o); end
    endtask

    task automatic test_coincident();
        drive_b(mk_b(7'h33, 1'b0, 1'b1), 0, 10, -1);
        tick();
        drive_b(mk_b(7'h44, 1'b0, 1'b1), 0, 10, 78);
        checks++; if (bus_b.rx_data_o !== 7'h44) begin errors++; $display("FAIL coinc_data: got %h expected 44", bus_b.rx_data_o); end
        checks++; if ({bus_b.rx_valid_o, bus_b.rx_overrun_o} !== 2'b10) begin errors++; $display("FAIL coinc_flags: got v=%b ov=%b expected 1 0", bus_b.rx_valid_o, bus_b.rx_overrun_o); end
        consume_b();
    endtask

    task automatic test_enable_drop();
        logic [10:0] f = mk_b(7'h2B, 1'b0, 1'b1);
        bus_a.tx_data_i = 8'h00;
        bus_a.tx_valid_i = 1'b1;
        tick();
        bus_a.tx_valid_i = 1'b0;
        drive_b(f, 0, 3, -1);
        checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL en_pre_drop_tx: got %b expected 0", tx_a); end
        en = 1'b0;
        tick();
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL en_drop_tx: got %b expected 1", tx_a); end
        checks++; if (bus_a.tx_ready_o !== 1'b0) begin errors++; $display("FAIL en_drop_ready: got %b expected 0", bus_a.tx_ready_o); end
        drive_b(f, 4, 10, -1);
        en = 1'b1;
        repeat (20) tick();
        checks++; if (bus_b.rx_valid_o !== 1'b0) begin errors++; $display("FAIL en_drop_rx: got %b expected 0", bus_b.rx_valid_o); end
        checks++; if ({bus_a.tx_ready_o, tx_a} !== 2'b11) begin errors++; $display("FAIL en_restore_tx: got ready=%b tx=%b expected 1 1", bus_a.tx_ready_o, tx_a); end
        drive_b(f, 0, 10, -1);
        checks++; if ({bus_b.rx_valid_o, bus_b.rx_data_o} !== {1'b1, 7'h2B}) begin errors++; $display("FAIL en_after_rx: got v=%b data=%h expected 1 2b", bus_b.rx_valid_o, bus_b.rx_data_o); end
        consume_b();
    endtask

    task automatic test_async_reset();
        drive_b(mk_b(7'h15, 1'b1, 1'b0), 0, 10, -1);
        tick();
        drive_b(mk_b(7'h16, 1'b0, 1'b1), 0, 10, -1);
        checks++; if ({bus_b.rx_valid_o, bus_b.rx_overrun_o, bus_b.rx_frame_err_o, bus_b.rx_parity_err_o} !== 4'b1111) begin
            errors++; $display("FAIL arst_pre: got v=%b ov=%b fe=%b pe=%b expected 1 1 1 1", bus_b.rx_valid_o, bus_b.rx_overrun_o, bus_b.rx_frame_err_o, bus_b.rx_parity_err_o);
        end
        bus_a.tx_data_i = 8'h00;
        bus_a.tx_valid_i = 1'b1;
        tick();
        bus_a.tx_valid_i = 1'b0;
        repeat (20) tick();
        drive_b(mk_b(7'h7F, 1'b0, 1'b1), 0, 2, -1);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL arst_tx: got %b expected 1", tx_a); end
        checks++; if (bus_a.tx_ready_o !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b expected 0", bus_a.tx_ready_o); end
        checks++; if ({bus_b.rx_valid_o, bus_b.rx_data_o, bus_b.rx_frame_err_o, bus_b.rx_parity_err_o, bus_b.rx_overrun_o} !== 11'd0) begin
            errors++; $display("FAIL arst_rx: got v=%b data=%h fe=%b pe=%b ov=%b expected all 0", bus_b.rx_valid_o, bus_b.rx_data_o, bus_b.rx_frame_err_o, bus_b.rx_parity_err_o, bus_b.rx_overrun_o);
        end
        #2 rst_n = 1'b1;
        rx_b = 1'b1;
        tick();
        checks++; if (bus_a.tx_ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready_after: got %b expected 1", bus_a.tx_ready_o); end
        repeat (100) tick();
        checks++; if (bus_b.rx_valid_o !== 1'b0) begin errors++; $display("FAIL arst_partial: got %b expected 0", bus_b.rx_valid_o); end
    endtask

    initial begin
        bus_a.tx_data_i = '0;
        bus_a.tx_valid_i = 1'b0;
        bus_a.rx_ready_i = 1'b0;
        bus_b.tx_data_i = '0;
        bus_b.tx_valid_i = 1'b0;
        bus_b.rx_ready_i = 1'b0;
        test_reset();
        test_tx_8n1();
        test_back_to_back();
        test_rx_clean();
        test_rx_parity();
        test_rx_frame_err();
        test_false_start();
        test_overrun();
        test_coincident();
        test_enable_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tthbif_uart.md
# tthbif_uart

Parametrised full-duplex UART transceiver, the successor to the fixed-format serial port on the `tthbif` host link. It generalises data width, parity mode, stop-bit count and baud divisor, and adds valid/ready handshakes on both directions. It also adds per-word framing/parity error reporting and sticky RX overrun detection. It sits between the top-level pins (`uart_rx_i`/`uart_tx_o`) and the `tthbif` command logic.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit; legal values ≥ 4.
- `DATA_W`, default 8: data bits per frame; legal values 5..9.
- `PARITY`, default 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1..2.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  block enable; low forces both FSMs idle.
- `tx_data_i`  in  DATA_W  word to transmit.
- `tx_valid_i`  in  1  TX word valid.
- `tx_ready_o`  out  1  TX can accept a word.
- `rx_data_o`  out  DATA_W  received word.
- `rx_valid_o`  out  1  RX word valid.
- `rx_ready_i`  in  1  consumer accepts the RX word.
- `rx_frame_err_o`  out  1  stop bit sampled low for the current word.
- `rx_parity_err_o`  out  1  parity mismatch for the current word (always 0 when PARITY = 0).
- `rx_overrun_o`  out  1  sticky flag: a completed frame was dropped.
- `uart_rx_i`  in  1  asynchronous serial input.
- `uart_tx_o`  out  1  serial output; idles high.

## Operation
- Frame format: start bit (0), then DATA_W data bits LSB first, then an optional parity bit, then STOP_BITS stop bits (1).
- Frame length: N = 1 + DATA_W + (PARITY != 0) + STOP_BITS bits.
- Odd parity: data bits plus parity bit contain an odd number of ones. Even parity: an even number.

TX FSM:
- States: IDLE → START → DATA → PARITY (skipped if PARITY = 0) → STOP → IDLE.
- `tx_ready_o` = (state == IDLE) & `en_i`.
- A transfer occurs on `tx_valid_i` & `tx_ready_o`; the word is latched on that cycle.
- A bit-cycle counter and a bit index advance each state; each bit is held exactly CLKS_PER_BIT cycles.

RX FSM:
- `uart_rx_i` passes through a 2-flop synchroniser first.
- States: IDLE → START → DATA → PARITY (skipped if PARITY = 0) → STOP → IDLE.
- IDLE: leaves on synchronised line == 0.
- START: waits CLKS_PER_BIT/2 cycles, then resamples. If the sample is 1, the start was false; return to IDLE with no output.
- Later bits are sampled every CLKS_PER_BIT cycles from the start-bit centre.
- Only the first stop bit is checked. After the stop sample, the FSM returns to IDLE immediately, at mid-stop-bit.

RX output register:
- On the stop sample, if `rx_valid_o` == 0: load `rx_data_o`, `rx_frame_err_o` and `rx_parity_err_o`, and set `rx_valid_o`. A word with errors is still delivered, with its flags set.
- If `rx_valid_o` == 1 at the stop sample: drop the new frame, keep the old word and flags, and set `rx_overrun_o`.
- `rx_valid_o` clears on `rx_valid_o` & `rx_ready_i`. `rx_overrun_o` clears on the same handshake, so it is visible alongside the word it follows.
- If a stop sample and a handshake land on the same cycle, the new word loads and `rx_valid_o` stays 1. No overrun is flagged.

`en_i` = 0:
- Both FSMs go synchronously to IDLE and their counters clear. Any frame in flight is abandoned.
- `uart_tx_o` = 1 and `tx_ready_o` = 0.
- The RX output register and the overrun flag hold.

## Timing
- Reset values:
  - `uart_tx_o` = 1.
  - `tx_ready_o` = 0 during reset; it asserts the first cycle after release if `en_i` = 1.
  - `rx_valid_o`, `rx_data_o`, `rx_frame_err_o`, `rx_parity_err_o` and `rx_overrun_o` all = 0.
  - Synchroniser flops reset to 1.
- TX latency: handshake at cycle t → `uart_tx_o` low from t+1 through t+CLKS_PER_BIT. Data bit k occupies cycles t+1+(k+1)·CLKS_PER_BIT onward. The last stop cycle is t+N·CLKS_PER_BIT.
- TX turnaround: back in IDLE with `tx_ready_o` = 1 at t+N·CLKS_PER_BIT+1. The minimum gap between frames is 1 idle-high cycle.
- RX latency:
  - Falling edge at line cycle e; the synchronised edge is seen at e+2.
  - Start sample at e+2+CLKS_PER_BIT/2.
  - Stop sample at e+2+CLKS_PER_BIT/2+(N−STOP_BITS)·CLKS_PER_BIT.
  - `rx_valid_o` rises the cycle after the stop sample.
- Asynchronous reset mid-frame: all state returns to reset values immediately. A partial RX frame is never delivered.

## Test plan
- **Reset/idle.** Assert `rst_ni` low mid-TX-frame → `uart_tx_o` = 1 and all RX outputs = 0 immediately; `tx_ready_o` = 1 one cycle after release.
- **TX 8N1, CLKS_PER_BIT = 8.**
  - Stimulus: send 0xA5.
  - Required: line reads 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
  - Required: `tx_ready_o` returns at handshake + 81.
- **RX loopback, even parity, DATA_W = 7, STOP_BITS = 2.**
  - Clean frame: drive 0x5A → `rx_data_o` = 0x5A, both error flags 0.
  - Parity bit inverted: same frame → `rx_parity_err_o` = 1, word still delivered.
- **Framing error and false start.**
  - Stop bit driven low → `rx_frame_err_o` = 1 with the word.
  - Low glitch of CLKS_PER_BIT/2 − 2 cycles on the line → no `rx_valid_o`.
- **Overrun.**
  - Hold `rx_ready_i` = 0 and receive 0x11 then 0x22 → `rx_data_o` stays 0x11, `rx_overrun_o` = 1.
  - Handshake → `rx_valid_o` and `rx_overrun_o` both 0 the next cycle.
  - Stop sample coincident with a handshake → new word loads, no overrun.
- **Enable drop.** Pull `en_i` low mid-TX and mid-RX frame → `uart_tx_o` = 1 the next cycle, no RX word is delivered, and a full frame after `en_i` returns high is received correctly.
